// File: rtl/i2c_target_regs.sv
// I2C target exposing a 16 x 8-bit register file.
// SCL/SDA are synchronized and glitch-filtered on the system clock.
// SDA is only ever pulled low; a local port reads registers and reports writes.
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h48,
    parameter int         FILT_LEN = 3
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    input  logic [3:0] i_reg_addr,
    output logic [7:0] o_reg_rdata,
    output logic       o_wr_stb,
    output logic [3:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    output logic       o_busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    localparam logic [2:0] FILT_MAX = 3'(FILT_LEN - 1);

    logic       scl_s1, scl_s2, sda_s1, sda_s2;
    logic       scl_f, sda_f, scl_p, sda_p;
    logic [2:0] scl_cnt, sda_cnt;
    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic [3:0] ptr;
    logic       rw;
    logic       ack_phase;
    logic [7:0] regs [16];

    logic       scl_rise, scl_fall, start_det, stop_det, commit;
    logic [7:0] rx_byte;

    // Two-flop synchronizers; the idle bus level is high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
        end else begin
            scl_s1 <= i_scl;
            scl_s2 <= scl_s1;
            sda_s1 <= i_sda;
            sda_s2 <= sda_s1;
        end
    end

    // Accept a new level only after FILT_LEN consecutive differing samples.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_f   <= 1'b1;
            sda_f   <= 1'b1;
            scl_cnt <= '0;
            sda_cnt <= '0;
        end else begin
            if (scl_s2 == scl_f) begin
                scl_cnt <= '0;
            end else if (scl_cnt == FILT_MAX) begin
                scl_f   <= scl_s2;
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 3'd1;
            end
            if (sda_s2 == sda_f) begin
                sda_cnt <= '0;
            end else if (sda_cnt == FILT_MAX) begin
                sda_f   <= sda_s2;
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 3'd1;
            end
        end
    end

    // Previous filtered levels for edge and START/STOP detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_p <= 1'b1;
            sda_p <= 1'b1;
        end else begin
            scl_p <= scl_f;
            sda_p <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_p;
    assign scl_fall  = ~scl_f & scl_p;
    assign start_det = scl_f & scl_p & sda_p & ~sda_f;
    assign stop_det  = scl_f & scl_p & ~sda_p & sda_f;
    assign rx_byte   = {shift[6:0], sda_f};
    assign commit    = (state == WDATA) && scl_rise && (bit_cnt == 3'd7);

    // Protocol state machine, register file writes and SDA drive.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            ptr       <= '0;
            rw        <= 1'b0;
            ack_phase <= 1'b0;
            o_sda_oe  <= 1'b0;
            o_wr_stb  <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            o_busy    <= 1'b0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            o_wr_stb <= 1'b0;
            if (start_det) begin
                state     <= ADDR;
                bit_cnt   <= '0;
                ack_phase <= 1'b0;
                o_sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state     <= IDLE;
                ack_phase <= 1'b0;
                o_sda_oe  <= 1'b0;
                o_busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    ADDR, PTR, WDATA: begin
                        if (scl_rise) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                ack_phase <= 1'b0;
                                if (state == ADDR) begin
                                    if (rx_byte[7:1] == DEV_ADDR) begin
                                        state  <= ADDR_ACK;
                                        rw     <= rx_byte[0];
                                        o_busy <= 1'b1;
                                    end else begin
                                        state  <= IDLE;
                                        o_busy <= 1'b0;
                                    end
                                end else if (state == PTR) begin
                                    ptr   <= rx_byte[3:0];
                                    state <= PTR_ACK;
                                end else begin
                                    regs[ptr] <= rx_byte;
                                    o_wr_stb  <= 1'b1;
                                    o_wr_addr <= ptr;
                                    o_wr_data <= rx_byte;
                                    ptr       <= ptr + 4'd1;
                                    state     <= WDATA_ACK;
                                end
                            end
                        end
                    end
                    ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                o_sda_oe  <= 1'b1;
                                ack_phase <= 1'b1;
                            end else begin
                                ack_phase <= 1'b0;
                                bit_cnt   <= '0;
                                if (state == ADDR_ACK && rw) begin
                                    state    <= RDATA;
                                    shift    <= regs[ptr];
                                    o_sda_oe <= ~regs[ptr][7];
                                end else begin
                                    o_sda_oe <= 1'b0;
                                    state    <= (state == ADDR_ACK) ? PTR : WDATA;
                                end
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_fall) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= {shift[6:0], 1'b0};
                            if (bit_cnt == 3'd7) begin
                                o_sda_oe  <= 1'b0;
                                ack_phase <= 1'b0;
                                state     <= RDATA_ACK;
                            end else begin
                                o_sda_oe <= ~shift[6];
                            end
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise && !ack_phase) begin
                            if (!sda_f) begin
                                ptr       <= ptr + 4'd1;
                                shift     <= regs[ptr + 4'd1];
                                ack_phase <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end else if (scl_fall && ack_phase) begin
                            state     <= RDATA;
                            bit_cnt   <= '0;
                            ack_phase <= 1'b0;
                            o_sda_oe  <= ~shift[7];
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Local read port; a write committing this cycle is forwarded.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_reg_rdata <= '0;
        end else if (commit && (ptr == i_reg_addr)) begin
            o_reg_rdata <= rx_byte;
        end else begin
            o_reg_rdata <= regs[i_reg_addr];
        end
    end

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

Synthesizable I2C target (responder) exposing a 16 x 8-bit register file to any I2C initiator. It sits on the far end of the SoC I2C controller pins (i2c_0 and the sensor buses) in simulation and loopback builds, so firmware I2C drivers can be exercised against a deterministic device. It oversamples SCL/SDA on the system clock and drives SDA open-drain only. A local port lets the bench or SoC read registers and observe every write.

## Interface
- DEV_ADDR, 7'h48, 7-bit target address matched on START.
- FILT_LEN, 3, number of identical consecutive synchronized samples required to accept a new SCL/SDA level (range 1-7).
- i_clk  in  1  system clock; all logic on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_scl  in  1  bus SCL level (resolved wire).
- i_sda  in  1  bus SDA level (resolved wire).
- o_sda_oe  out  1  1 = pull SDA low; 0 = release. The driven value is always 0.
- i_reg_addr  in  4  local read index.
- o_reg_rdata  out  8  registered read data: regs[i_reg_addr], one cycle after i_reg_addr.
- o_wr_stb  out  1  one-cycle pulse when an I2C write byte commits.
- o_wr_addr  out  4  register index of the committed write (valid with o_wr_stb).
- o_wr_data  out  8  committed data (valid with o_wr_stb).
- o_busy  out  1  high from an accepted address match until STOP, or until a START that does not match.

## Operation
- Input conditioning: 2-FF synchronizer per line, then a FILT_LEN-deep glitch filter giving scl_f and sda_f. Edge and condition detection uses only the filtered signals.
- START: sda_f falls while scl_f is high. STOP: sda_f rises while scl_f is high. A START is honoured in any state, which covers repeated START.
- Bits are sampled on the scl_f rising edge, MSB first.
- SDA changes only on the cycle after a scl_f falling edge is detected.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- IDLE: wait for START, then go to ADDR and clear the bit counter.
- ADDR: shift 8 bits (7 address bits plus R/W).
  - Match: go to ADDR_ACK and drive ACK.
  - Mismatch: leave SDA released (NACK) and return to IDLE.
- ADDR_ACK: next state depends on R/W.
  - W: go to PTR.
  - R: go to RDATA and load shift register = regs[ptr].
- PTR: receive 8 bits; ptr = byte[3:0] and bits [7:4] are ignored. Drive ACK in PTR_ACK, then go to WDATA.
- WDATA: receive 8 bits. On the 8th scl_f rise:
  - regs[ptr] <= byte.
  - o_wr_stb pulses with o_wr_addr = ptr and o_wr_data = byte.
  - ptr increments.
  - Then drive ACK in WDATA_ACK and return to WDATA.
- RDATA: drive each bit (a 0 pulls SDA low, a 1 releases it) for 8 bits, then go to RDATA_ACK and release SDA. Sample the initiator ACK on the 9th scl_f rise:
  - ACK (0): ptr increments, load regs[ptr+1], go to RDATA.
  - NACK (1): go to IDLE and keep SDA released.
- ACK drive window: from the scl_f fall after bit 8 to the scl_f fall after bit 9.
- Pointer is 4 bits and wraps 15 -> 0 on both read and write.
- STOP in any state: release SDA, go to IDLE, clear o_busy. ptr and regs are retained.
- START mid-byte: the partial byte is discarded with no write and no ptr change. Go to ADDR.
- Collisions: none are handled. The target never drives SDA high.

## Timing
- Reset values: o_sda_oe = 0, o_wr_stb = 0, o_wr_addr = 0, o_wr_data = 0, o_busy = 0, o_reg_rdata = 0, regs = 0, ptr = 0, state = IDLE. Filters reset to the line-high level.
- Reset mid-transfer releases SDA asynchronously. The block then waits for a fresh START.
- Input latency: a bus edge reaches the filtered signal after 2 + FILT_LEN cycles.
- o_sda_oe update: 1 cycle after a filtered edge is detected.
- Bus-clock limit: each SCL phase must exceed 2·(2 + FILT_LEN) + 2 i_clk cycles (e.g. 100 MHz supports 400 kHz with large margin).
- o_wr_stb: exactly 1 cycle, on the cycle after the 8th data-bit scl_f rise is detected.
- Local read: o_reg_rdata reflects same-cycle writes on the following cycle (write-first).
- Simultaneous I2C write commit and local read of the same index: o_reg_rdata returns the new value.

## Test plan
- Write then read: S 0x90 P0 0x03 P0 0xA5 P0 P → ACK on all three bytes; o_wr_stb once with addr 3, data 0xA5. Then S 0x90 0x03 Sr 0x91 → target returns 0xA5; initiator NACK; SDA released.
- Address mismatch: S 0x92 → SDA stays released through the 9th clock; o_busy stays 0; no writes occur.
- Burst wrap: write pointer 0x0E, then data 0x11, 0x22, 0x33 → regs[14] = 0x11, regs[15] = 0x22, regs[0] = 0x33; three strobes with addrs 14, 15, 0.
- Sequential read: regs[0..2] = 01, 02, 03; read 3 bytes from ptr 0, ACKing the first two and NACKing the third → bus sees 01 02 03; ptr = 2 afterwards.
- Abort: START after 4 bits of a data byte → no o_wr_stb and ptr unchanged; next addressed transfer is ACKed. Assert i_rst_n low while the target drives ACK → o_sda_oe = 0 immediately.
- Glitch: a 1-cycle low pulse on SCL while SDA toggles (FILT_LEN = 3) → no START, STOP, or bit detected; state unchanged.
